// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// opcode/funct values, ALU control codes and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXEC,
    ALUWB,
    BRANCH,
    ADDIEX,
    ADDIWB,
    JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// R-type funct decoder.
//   funct    : instr[5:0]
//   alu_code : 3-bit ALU operation (add when funct is unsupported)
//   valid    : funct is one of add/sub/and/or/slt
module mc_aludec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_code,
  output logic       valid
);

  always_comb begin
    alu_code = ALU_ADD;
    valid    = 1'b1;
    case (funct)
      FN_ADD:  alu_code = ALU_ADD;
      FN_SUB:  alu_code = ALU_SUB;
      FN_AND:  alu_code = ALU_AND;
      FN_OR:   alu_code = ALU_OR;
      FN_SLT:  alu_code = ALU_SLT;
      default: valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: sequences each instruction through
// fetch/decode/execute/memory/writeback over a shared ALU and memory port.
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4 (waits on mem_ready)
// DECODE | branch target into ALUOut, dispatch on opcode
// MEMADR | compute lw/sw effective address
// MEMRD  | load data read (waits on mem_ready)
// MEMWB  | load result into rt
// MEMWR  | store data write (waits on mem_ready)
// EXEC   | R-type ALU operation
// ALUWB  | R-type result into rd
// BRANCH | beq compare, PC <= ALUOut when zero
// ADDIEX | addi ALU operation
// ADDIWB | addi result into rt
// JUMP   | PC <= jump target
//
// Inputs : clk, reset (sync, active-high), opcode, funct, zero, mem_ready
// Outputs: datapath enables/selects, alucontrol, illegal and instr_done pulses
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter bit MEM_WAIT  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_en,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_src,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal,
  output logic                 instr_done
);

  state_t     state;
  logic       ready;
  logic       op_legal;
  logic [2:0] dec_code;
  logic       dec_valid;
  logic [2:0] alu_op;

  assign ready = MEM_WAIT ? mem_ready : 1'b1;

  always_comb begin
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  end

  mc_aludec u_aludec (
    .funct    (funct),
    .alu_code (dec_code),
    .valid    (dec_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:  if (ready) state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= MEMADR;
            OP_RTYPE:     state <= EXEC;
            OP_BEQ:       state <= BRANCH;
            OP_ADDI:      state <= ADDIEX;
            OP_J:         state <= JUMP;
            default:      state <= FETCH;
          endcase
        end
        MEMADR: state <= (opcode == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  if (ready) state <= MEMWB;
        MEMWR:  if (ready) state <= FETCH;
        EXEC:   state <= dec_valid ? ALUWB : FETCH;
        ADDIEX: state <= ADDIWB;
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_src     = PC_ALU;
    illegal    = 1'b0;
    instr_done = 1'b0;
    alu_op     = ALU_ADD;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = ready;
        pc_en     = ready;
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        if (!op_legal) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
        end
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = ready;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = dec_code;
        if (!dec_valid) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
        end
      end
      ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = PC_ALUOUT;
        pc_en      = zero;
        instr_done = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_src     = PC_JUMP;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase

    // Reset forces everything quiet, including the ALU code, so an access
    // in flight is dropped immediately rather than at the next edge.
    if (reset) begin
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      pc_src     = PC_ALU;
      illegal    = 1'b0;
      instr_done = 1'b0;
      alu_op     = 3'b000;
    end
    alucontrol = ALUCTRL_W'(alu_op);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed and randomized checks of multicycle_controller against an
// instruction-level model that expands each instruction into its
// expected per-cycle control pattern.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu;
    logic       illegal;
    logic       instr_done;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, illegal, instr_done;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alucontrol;

  int checks = 0;
  int errors = 0;

  outs_t q_exp[$];
  logic  q_rdy[$];

  multicycle_controller #(.ALUCTRL_W(3), .MEM_WAIT(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic outs_t idle();
    outs_t o = '0;
    o.alu = 3'b010;
    return o;
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] fn, output logic ok);
    ok = 1'b1;
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default: begin ok = 1'b0; return 3'b010; end
    endcase
  endfunction

  // Cycles where mem_ready is irrelevant get a random value on it.
  task automatic push(input outs_t o);
    q_rdy.push_back(1'($urandom_range(0, 1)));
    q_exp.push_back(o);
  endtask

  task automatic push_wait(input outs_t o_wait, input outs_t o_done, input int stalls);
    for (int i = 0; i < stalls; i++) begin
      q_rdy.push_back(1'b0);
      q_exp.push_back(o_wait);
    end
    q_rdy.push_back(1'b1);
    q_exp.push_back(o_done);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fs, input int ms);
    outs_t f, fd, d, a, m, md, w;
    logic ok;
    q_exp.delete();
    q_rdy.delete();
    f = idle(); f.mem_read = 1'b1; f.alu_src_b = 2'b01;
    fd = f; fd.ir_write = 1'b1; fd.pc_en = 1'b1;
    push_wait(f, fd, fs);
    d = idle(); d.alu_src_b = 2'b11;
    a = idle(); a.alu_src_a = 1'b1; a.alu_src_b = 2'b10;
    case (op)
      6'b100011: begin
        push(d); push(a);
        m = idle(); m.mem_read = 1'b1; m.iord = 1'b1;
        push_wait(m, m, ms);
        w = idle(); w.reg_write = 1'b1; w.mem_to_reg = 1'b1; w.instr_done = 1'b1;
        push(w);
      end
      6'b101011: begin
        push(d); push(a);
        m = idle(); m.mem_write = 1'b1; m.iord = 1'b1;
        md = m; md.instr_done = 1'b1;
        push_wait(m, md, ms);
      end
      6'b000000: begin
        push(d);
        m = idle(); m.alu_src_a = 1'b1; m.alu = r_alu(fn, ok);
        if (!ok) begin m.illegal = 1'b1; m.instr_done = 1'b1; end
        push(m);
        if (ok) begin
          w = idle(); w.reg_write = 1'b1; w.reg_dst = 1'b1; w.instr_done = 1'b1;
          push(w);
        end
      end
      6'b000100: begin
        push(d);
        m = idle(); m.alu_src_a = 1'b1; m.alu = 3'b110; m.pc_src = 2'b01;
        m.pc_en = z; m.instr_done = 1'b1;
        push(m);
      end
      6'b001000: begin
        push(d); push(a);
        w = idle(); w.reg_write = 1'b1; w.instr_done = 1'b1;
        push(w);
      end
      6'b000010: begin
        push(d);
        m = idle(); m.pc_src = 2'b10; m.pc_en = 1'b1; m.instr_done = 1'b1;
        push(m);
      end
      default: begin
        d.illegal = 1'b1; d.instr_done = 1'b1;
        push(d);
      end
    endcase
  endtask

  task automatic step(input logic rst, input logic rdy, input outs_t e,
                      input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input string tag, input int cyc);
    outs_t got;
    @(posedge clk);
    #1;
    reset = rst; mem_ready = rdy; opcode = op; funct = fn; zero = z;
    @(negedge clk);
    got = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_src, alucontrol, illegal, instr_done};
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, got, e);
    end
    checks++;
    assert ({mem_read & mem_write, reg_write & mem_write} === 2'b00) else begin
      errors++;
      $error("FAIL %s_excl cycle %0d: observed rd/wr/rw %b%b%b expected no overlap",
             tag, cyc, mem_read, mem_write, reg_write);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fs, input int ms, input string tag);
    build(op, fn, z, fs, ms);
    for (int i = 0; i < q_exp.size(); i++)
      step(1'b0, q_rdy[i], q_exp[i], op, fn, z, tag, i);
  endtask

  function automatic logic legal_op(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  initial begin
    logic [5:0] op, fn;
    logic       z;
    int         sel;
    int         n_lw;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, '0, 6'd0, 6'd0, 1'b0, "reset", i);

    run_instr(6'b100011, 6'd0, 1'b0, 0, 0, "lw");
    run_instr(6'b101011, 6'd0, 1'b0, 0, 2, "sw_wait");
    run_instr(6'b000100, 6'd0, 1'b1, 0, 0, "beq_taken");
    run_instr(6'b000100, 6'd0, 1'b0, 0, 0, "beq_not");
    run_instr(6'b000000, 6'b101010, 1'b0, 0, 0, "r_slt");
    run_instr(6'b000000, 6'b000111, 1'b0, 0, 0, "r_bad");
    run_instr(6'b111111, 6'd0, 1'b0, 0, 0, "op_bad");
    run_instr(6'b001000, 6'd0, 1'b0, 2, 0, "addi_fwait");
    run_instr(6'b000010, 6'd0, 1'b0, 1, 0, "j");

    // lw abandoned by reset while MEMRD is waiting: fetch, decode,
    // memadr, first MEMRD wait cycle, then reset, then a fresh FETCH.
    build(6'b100011, 6'd0, 1'b0, 0, 3);
    n_lw = 4;
    for (int i = 0; i < n_lw; i++)
      step(1'b0, q_rdy[i], q_exp[i], 6'b100011, 6'd0, 1'b0, "lw_abort", i);
    step(1'b1, 1'b1, '0, 6'b100011, 6'd0, 1'b0, "lw_abort_rst", 0);
    run_instr(6'b000010, 6'd0, 1'b0, 0, 0, "after_rst");

    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 7);
      fn  = 6'($urandom_range(0, 63));
      z   = 1'($urandom_range(0, 1));
      case (sel)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: begin
          op = 6'b000000;
          case ($urandom_range(0, 4))
            0: fn = 6'b100000;
            1: fn = 6'b100010;
            2: fn = 6'b100100;
            3: fn = 6'b100101;
            default: fn = 6'b101010;
          endcase
        end
        3: op = 6'b000000;
        4: op = 6'b000100;
        5: op = 6'b001000;
        6: op = 6'b000010;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (legal_op(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      run_instr(op, fn, z, $urandom_range(0, 2), $urandom_range(0, 3), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
